// File: rtl/calc_display_driver.sv
// calc_display_driver
// Converts the calculator's 28-bit result magnitude into eight BCD digits
// with an iterative double-dabble FSM, then scans them onto an 8-digit
// common-anode 7-segment display. Leading zeros are blanked. Overflow or
// out-of-range results show an "E" pattern. A separate LED shows the minus sign.
module calc_display_driver #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [27:0] value,
  input  logic        sign,
  input  logic        overflow,
  output logic [7:0]  digit_sel,
  output logic [6:0]  seg,
  output logic        minus_led,
  output logic        busy
);

  // Scan counter width: large enough to hold SCAN_DIV-1 (SCAN_DIV >= 2).
  localparam int                SCAN_W    = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

  // Largest magnitude that fits in eight decimal digits.
  localparam logic [27:0] MAX_SHOWN = 28'd99_999_999;

  // The conversion takes 28 shifts, so the count runs 0..27.
  localparam logic [4:0]  LAST_SHIFT = 5'd27;

  // Segment patterns, active low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam logic [6:0]  SEG_ERR   = 7'b0000110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Add 3 to a BCD nibble that is 5 or more. This pre-corrects the digit
  // before the doubling shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Apply the add-3 correction to all eight accumulator nibbles.
  function automatic logic [31:0] bcd_adjust(input logic [31:0] bcd);
    logic [31:0] res;
    res = bcd;
    for (int k = 0; k < 8; k++) begin
      res[k*4 +: 4] = add3(bcd[k*4 +: 4]);
    end
    return res;
  endfunction

  // Decode one BCD digit to active-low segments. Non-decimal codes show blank.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] res;
    case (digit)
      4'd0:    res = 7'b1000000;
      4'd1:    res = 7'b1111001;
      4'd2:    res = 7'b0100100;
      4'd3:    res = 7'b0110000;
      4'd4:    res = 7'b0011001;
      4'd5:    res = 7'b0010010;
      4'd6:    res = 7'b0000010;
      4'd7:    res = 7'b1111000;
      4'd8:    res = 7'b0000000;
      4'd9:    res = 7'b0010000;
      default: res = SEG_BLANK;
    endcase
    return res;
  endfunction

  // Conversion state
  state_t      r_state;
  state_t      w_state_nxt;
  logic [27:0] r_snap_value;
  logic        r_snap_sign;
  logic        r_snap_ovf;
  logic [31:0] r_bcd_acc;
  logic [27:0] r_shreg;
  logic [4:0]  r_shift_cnt;

  // Display state
  logic [31:0] r_disp_bcd;
  logic        r_err;
  logic        r_neg;

  // Scan state and registered outputs
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [2:0]        r_digit_idx;
  logic [7:0]        r_digit_sel;
  logic [6:0]        r_seg;
  logic              r_minus_led;

  // Combinational helpers
  logic        w_snap_diff;
  logic        w_capture;
  logic        w_shifting;
  logic        w_finish;
  logic        w_last_shift;
  logic [31:0] w_bcd_adj;
  logic [31:0] w_bcd_next;
  logic [27:0] w_shreg_next;
  logic        w_range_err;
  logic [3:0]  w_nibble;
  logic [31:0] w_upper;
  logic        w_upper_zero;
  logic [7:0]  w_sel_nxt;
  logic [6:0]  w_seg_nxt;

  // A new conversion is needed whenever the inputs differ from the last snapshot.
  assign w_snap_diff  = ({value, sign, overflow} !=
                         {r_snap_value, r_snap_sign, r_snap_ovf});
  assign w_last_shift = (r_shift_cnt == LAST_SHIFT);

  // Each shift step does both things in one cycle. It first corrects every
  // nibble, then shifts {bcd, shreg} left by one bit.
  assign w_bcd_adj    = bcd_adjust(r_bcd_acc);
  assign w_bcd_next   = {w_bcd_adj[30:0], r_shreg[27]};
  assign w_shreg_next = {r_shreg[26:0], 1'b0};

  // Overflow from the core, or a magnitude too wide for eight digits.
  assign w_range_err  = r_snap_ovf | (r_snap_value > MAX_SHOWN);

  // Next-state logic and the per-state datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_shifting  = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_snap_diff) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_shifting = 1'b1;
        if (w_last_shift) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_DONE: begin
        w_finish    = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register. Reset aborts any conversion in flight.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Snapshot, shift register and accumulator. The display registers are
  // loaded only when a conversion completes.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_snap_value <= 28'd0;
      r_snap_sign  <= 1'b0;
      r_snap_ovf   <= 1'b0;
      r_bcd_acc    <= 32'd0;
      r_shreg      <= 28'd0;
      r_shift_cnt  <= 5'd0;
      r_disp_bcd   <= 32'd0;
      r_err        <= 1'b0;
      r_neg        <= 1'b0;
    end else begin
      if (w_capture) begin
        r_snap_value <= value;
        r_snap_sign  <= sign;
        r_snap_ovf   <= overflow;
        r_bcd_acc    <= 32'd0;
        r_shreg      <= value;
        r_shift_cnt  <= 5'd0;
      end else if (w_shifting) begin
        r_bcd_acc    <= w_bcd_next;
        r_shreg      <= w_shreg_next;
        r_shift_cnt  <= r_shift_cnt + 5'd1;
      end
      if (w_finish) begin
        r_disp_bcd <= r_bcd_acc;
        r_err      <= w_range_err;
        r_neg      <= r_snap_sign;
      end
    end
  end

  // Scan timing. Each digit stays lit for SCAN_DIV cycles, then the index
  // moves to the next digit and wraps from 7 back to 0.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= 3'd0;
    end else if (r_scan_cnt == SCAN_LAST) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= r_digit_idx + 3'd1;
    end else begin
      r_scan_cnt  <= r_scan_cnt + SCAN_ONE;
    end
  end

  // Current digit nibble. The digit is a leading zero when every nibble
  // from this position upward is zero.
  assign w_nibble     = r_disp_bcd[{r_digit_idx, 2'b00} +: 4];
  assign w_upper      = r_disp_bcd >> {r_digit_idx, 2'b00};
  assign w_upper_zero = (w_upper == 32'd0);

  // Segment and digit-select pattern for the current scan index.
  always_comb begin
    w_sel_nxt = ~(8'd1 << r_digit_idx);
    w_seg_nxt = SEG_BLANK;
    if (r_err) begin
      if (r_digit_idx == 3'd0) begin
        w_seg_nxt = SEG_ERR;
      end else begin
        w_seg_nxt = SEG_BLANK;
      end
    end else if ((r_digit_idx != 3'd0) && w_upper_zero) begin
      w_seg_nxt = SEG_BLANK;
    end else begin
      w_seg_nxt = seg_encode(w_nibble);
    end
  end

  // Register the display outputs so digit_sel and seg always change together.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_digit_sel <= 8'hFE;
      r_seg       <= SEG_BLANK;
      r_minus_led <= 1'b0;
    end else begin
      r_digit_sel <= w_sel_nxt;
      r_seg       <= w_seg_nxt;
      r_minus_led <= r_neg & ~r_err;
    end
  end

  assign digit_sel = r_digit_sel;
  assign seg       = r_seg;
  assign minus_led = r_minus_led;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
Output-side partner of the calculator core. Takes its 28-bit result magnitude, sign and overflow flags, and converts the magnitude to 8 BCD digits with an iterative double-dabble FSM. It then drives a time-multiplexed 8-digit common-anode 7-segment display with leading-zero blanking, a separate minus LED and an error pattern.

Parameters:
SCAN_DIV, 50000, sys_clk cycles each digit is lit; legal range >= 2 (benches use 4).

Ports:
sys_clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on sys_clk rising edge
value  input  28  unsigned magnitude to show (calculator out)
sign  input  1  1 = negative result
overflow  input  1  1 = calculator halted on overflow
digit_sel  output  8  active-low one-hot digit enable; bit0 = rightmost digit
seg  output  7  active-low segments {g,f,e,d,c,b,a}
minus_led  output  1  active-high minus indicator
busy  output  1  1 while a conversion is in progress (state != IDLE)

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; snapshot {value,sign,overflow}=0; display BCD register=0; err=0; neg=0.
  - Shift counter=0; scan counter=0; digit index=0.
  - Outputs: digit_sel=8'hFE, seg=7'h7F, minus_led=0, busy=0.
  - Reset mid-conversion aborts the conversion; display returns to "0".
- FSM IDLE/SHIFT/DONE:
  - IDLE: if {value,sign,overflow} != snapshot at an edge (capture edge E0), capture all three, clear the 32-bit BCD accumulator, load the 28-bit shift register with value, shift count=0, go to SHIFT.
  - SHIFT: each edge, add 3 to every accumulator nibble >= 5, then shift {bcd,shreg} left 1 (both in one cycle). After the 28th shift (edge E28), go to DONE.
  - DONE: at E29, copy the accumulator to the display BCD register. err = snapshot overflow OR snapshot value > 99_999_999. neg = snapshot sign. Go to IDLE.
  - Latency: capture edge to displayed update = 29 cycles.
  - Input changes during SHIFT/DONE are ignored. At the next IDLE edge the mismatch is detected and the latest value is converted; there is no queueing.
- Digit decode for index i:
  - err=1: digit0 shows "E" (7'b0000110); digits 1..7 blank (7'h7F).
  - Otherwise: digit i blank if i>0 and all nibbles i..7 are zero (leading-zero blanking); digit0 always shown.
  - Encodings 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
- minus_led = neg & ~err, registered. Zero with sign=1 still lights minus.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1. On wrap, digit index increments mod 8 (7 -> 0).
  - digit_sel and seg are registered each cycle from the current index and display register. Output lags the index by one cycle; digit_sel and seg always change together.
- busy is combinational from state.

Test Plan:
1. Reset, SCAN_DIV=4, value=0 held -> first cycle after reset digit_sel=FE, seg=1000000; digit index steps every 4 cycles, wraps 7->0 after 32 cycles; digits 1..7 are 7F.
2. value=1234, sign=0 -> busy high for 29 cycles; after E29, digit0..3 show 4,3,2,1 (0011001, 0110000, 0100100, 1111001); digits 4..7 blank; minus_led=0.
3. value=99_980_001, sign=1 -> digits 7..0 show 9,9,9,8,0,0,0,1 (internal zeros not blanked); minus_led=1.
4. overflow=1, value=123 -> digit0=0000110, all other digits blank, minus_led=0. Also value=100_000_000 with overflow=0 -> same error pattern.
5. value changes 5 -> 77 at E10 of a conversion -> 5 displayed at E29; a second conversion starts next cycle; 77 displayed 30 cycles later.
6. rst_n pulsed low during SHIFT with value=4321 -> busy=0, display "0"; after release, a reconversion starts (snapshot mismatch) and 4321 appears 29 cycles after the capture edge.
